// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and helpers for btn_event_arb
package btn_pkg;

  localparam logic EV_PRESS = 1'b0;
  localparam logic EV_LONG  = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // All-ones terminal count of a bits-wide free-running prescaler
  function automatic logic [31:0] tick_tc(input int bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/btn_rr_arb.sv
// rtl/btn_rr_arb.sv - combinational round-robin picker: first requester at or after ptr
module btn_rr_arb import btn_pkg::*; #(
  parameter int N_BTN = 4,
  parameter int IDX_W = idx_w(N_BTN)
) (
  input  logic [N_BTN-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             gnt_any_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_BTN);

  logic [2*N_BTN-1:0] req2;
  logic [N_BTN-1:0]   rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate requests so bit 0 is the ptr position, then take the lowest set bit
  always_comb begin
    req2      = {req_i, req_i} >> ptr_i;
    rot       = req2[N_BTN-1:0];
    gnt_any_o = |rot;
    off       = '0;
    for (int k = N_BTN-1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    sum       = {1'b0, ptr_i} + {1'b0, off};
    gnt_idx_o = (sum >= N_L) ? IDX_W'(sum - N_L) : IDX_W'(sum);
  end

endmodule

// File: rtl/btn_event_arb.sv
// rtl/btn_event_arb.sv - shared-tick button debouncer with round-robin event output
// Optional long-press events are enabled by defining BTN_LONGPRESS_EN.
module btn_event_arb import btn_pkg::*; #(
  parameter int N_BTN      = 4,
  parameter int TICK_BITS  = 20,
  parameter int LONG_TICKS = 50
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [N_BTN-1:0]         i_btn,
  input  logic                     i_ovr_clr,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [idx_w(N_BTN)-1:0]  o_idx,
  output logic                     o_long,
  output logic [N_BTN-1:0]         o_overrun
);

  localparam int IDX_W = idx_w(N_BTN);
  localparam logic [TICK_BITS-1:0] TICK_TC  = TICK_BITS'(tick_tc(TICK_BITS));
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_BTN-1);

  logic [TICK_BITS-1:0] cnt_q;
  logic                 tick;
  logic [N_BTN-1:0]     s1_q, s2_q, press_edge;
  logic [N_BTN-1:0]     pending_q, pending_d, ovr_q, ovr_d;
  logic [N_BTN-1:0]     req, ld_vec, ld_press, ovr_long;
  logic                 ev_long;
  logic                 valid_q, valid_d, long_q, long_d;
  logic [IDX_W-1:0]     idx_q, idx_d, ptr_q, ptr_d, gnt_idx;
  logic                 gnt_any, load;

  assign tick       = (cnt_q == TICK_TC);
  assign press_edge = {N_BTN{tick}} & s1_q & ~s2_q;
  assign load       = (~valid_q | i_ready) & gnt_any;
  assign ld_vec     = load ? (N_BTN'(1) << gnt_idx) : '0;

  btn_rr_arb #(.N_BTN(N_BTN), .IDX_W(IDX_W)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

`ifdef BTN_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_TICKS+1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(LONG_TICKS-1);

  logic [HOLD_W-1:0] hold_q [N_BTN];
  logic [HOLD_W-1:0] hold_d [N_BTN];
  logic [N_BTN-1:0]  plong_q, plong_d, long_hit, ld_long;

  // A pending press always wins over a pending long event of the same button
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      long_hit[i] = tick & s2_q[i] & (hold_q[i] == HOLD_HIT);
      if (!s2_q[i])                          hold_d[i] = '0;
      else if (tick && hold_q[i] != HOLD_MAX) hold_d[i] = hold_q[i] + HOLD_W'(1);
      else                                   hold_d[i] = hold_q[i];
    end
    req      = pending_q | plong_q;
    ld_press = ld_vec & pending_q;
    ld_long  = ld_vec & ~pending_q & plong_q;
    ev_long  = (|ld_long) ? EV_LONG : EV_PRESS;
    plong_d  = long_hit | (plong_q & ~ld_long);
    ovr_long = long_hit & plong_q & ~ld_long;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      plong_q <= '0;
      for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
    end else begin
      plong_q <= plong_d;
      for (int i = 0; i < N_BTN; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  localparam int unused_long_ticks = LONG_TICKS;

  always_comb begin
    req      = pending_q;
    ld_press = ld_vec;
    ev_long  = EV_PRESS;
    ovr_long = '0;
  end
`endif

  // An edge in the same cycle its button is loaded keeps the new event without overrun
  always_comb begin
    pending_d = press_edge | (pending_q & ~ld_press);
    ovr_d     = (ovr_q & ~{N_BTN{i_ovr_clr}}) | (press_edge & pending_q & ~ld_press) | ovr_long;
    valid_d   = valid_q;
    idx_d     = idx_q;
    long_d    = long_q;
    ptr_d     = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      idx_d   = gnt_idx;
      long_d  = ev_long;
      ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      pending_q <= '0;
      ovr_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      long_q    <= 1'b0;
      ptr_q     <= '0;
    end else begin
      cnt_q     <= cnt_q + TICK_BITS'(1);
      if (tick) begin
        s1_q <= i_btn;
        s2_q <= s1_q;
      end
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      long_q    <= long_d;
      ptr_q     <= ptr_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_idx     = idx_q;
  assign o_long    = long_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_btn_event_arb.sv
// tb/tb_btn_event_arb.sv - directed and random bench for btn_event_arb against a behavioural model
module tb_btn_event_arb;

  localparam int N  = 4;
  localparam int TB = 2;
  localparam int LT = 3;
  localparam int TP = 1 << TB;

  logic       clk = 1'b0;
  logic       rst_n, ovr_clr, ready, valid, olong;
  logic [3:0] btn, ovr;
  logic [1:0] idx;

  always #5 clk = ~clk;

  btn_event_arb #(.N_BTN(N), .TICK_BITS(TB), .LONG_TICKS(LT)) dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .i_btn     (btn),
    .i_ovr_clr (ovr_clr),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_idx     (idx),
    .o_long    (olong),
    .o_overrun (ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: cycle count since reset, sampled buttons, event flags
  int cyc, m_idx, m_rr;
  int m_hold [N];
  bit m_s1 [N], m_s2 [N], m_pend [N], m_plong [N], m_ovr [N];
  bit m_valid, m_long;

  int ev_idx [$];
  int ev_cyc [$];
  bit ev_long [$];
  int tcyc = 0;

  task automatic model_reset();
    cyc = 0; m_idx = 0; m_rr = 0; m_valid = 0; m_long = 0;
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_pend[i] = 0; m_plong[i] = 0; m_ovr[i] = 0; m_hold[i] = 0;
    end
  endtask

  task automatic model_step();
    bit tk;
    bit e [N];
    bit lh [N];
    int w;
    tk = ((cyc % TP) == TP - 1);
    w = -1;
    for (int i = 0; i < N; i++) begin
      e[i]  = tk && m_s1[i] && !m_s2[i];
      lh[i] = 0;
`ifdef BTN_LONGPRESS_EN
      lh[i] = tk && m_s2[i] && (m_hold[i] == LT - 1);
`endif
    end
    if (!m_valid || ready) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (w < 0 && (m_pend[j] || m_plong[j])) w = j;
      end
    end
    if (w >= 0) begin
      m_valid = 1; m_idx = w; m_rr = (w + 1) % N;
      if (m_pend[w]) begin m_long = 0; m_pend[w] = 0; end
      else begin m_long = 1; m_plong[w] = 0; end
    end else if (ready) begin
      m_valid = 0;
    end
    if (ovr_clr) for (int i = 0; i < N; i++) m_ovr[i] = 0;
    for (int i = 0; i < N; i++) begin
      if (e[i]) begin if (m_pend[i]) m_ovr[i] = 1; m_pend[i] = 1; end
      if (lh[i]) begin if (m_plong[i]) m_ovr[i] = 1; m_plong[i] = 1; end
      if (!m_s2[i]) m_hold[i] = 0;
      else if (tk && m_hold[i] < LT) m_hold[i]++;
      if (tk) begin m_s2[i] = m_s1[i]; m_s1[i] = btn[i]; end
    end
    cyc++;
  endtask

  function automatic logic [3:0] m_ovr_vec();
    logic [3:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovr[i];
    return v;
  endfunction

  task automatic cycle();
    if (rst_n && valid && ready) begin
      ev_idx.push_back(int'(idx)); ev_long.push_back(olong); ev_cyc.push_back(tcyc);
    end
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    tcyc++;
    chk("valid", valid, m_valid);
    chk("idx", idx, m_idx);
    chk("long", olong, m_long);
    chk("overrun", ovr, m_ovr_vec());
  endtask

  task automatic clr_log();
    ev_idx.delete(); ev_long.delete(); ev_cyc.delete();
  endtask

  task automatic align();
    for (int k = 0; k < TP && (cyc % TP) != 0; k++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn = '0; ovr_clr = 1'b0;
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    clr_log();
  endtask

  task automatic press(input int b, input int hold_clk);
    align();
    btn[b] = 1'b1;
    repeat (hold_clk) cycle();
    btn[b] = 1'b0;
    repeat (8) cycle();
  endtask

  initial begin
    rst_n = 1'b0; btn = '0; ovr_clr = 1'b0; ready = 1'b1;
    model_reset();
    repeat (3) cycle();
    chk("rst_valid", valid, 0);
    chk("rst_overrun", ovr, 0);
    rst_n = 1'b1;

    // 1: single held press
    clr_log();
    press(2, 20);
    repeat (8) cycle();
`ifdef BTN_LONGPRESS_EN
    chk("t1_count", ev_idx.size(), 2);
    if (ev_idx.size() == 2) begin
      chk("t1_idx1", ev_idx[1], 2);
      chk("t1_long1", ev_long[1], 1);
    end
`else
    chk("t1_count", ev_idx.size(), 1);
`endif
    if (ev_idx.size() >= 1) begin
      chk("t1_idx0", ev_idx[0], 2);
      chk("t1_long0", ev_long[0], 0);
    end

    // 2: glitch between ticks
    clr_log();
    align();
    btn[1] = 1'b1;
    repeat (2) cycle();
    btn[1] = 1'b0;
    repeat (16) cycle();
    chk("t2_count", ev_idx.size(), 0);

    // 3: simultaneous presses served in round-robin order
    do_reset();
    btn = 4'b1011;
    repeat (12) cycle();
    btn = '0;
    repeat (16) cycle();
    chk("t3_count", ev_idx.size(), 3);
    if (ev_idx.size() == 3) begin
      chk("t3_idx0", ev_idx[0], 0);
      chk("t3_idx1", ev_idx[1], 1);
      chk("t3_idx2", ev_idx[2], 3);
      chk("t3_gap0", ev_cyc[1] - ev_cyc[0], 1);
      chk("t3_gap1", ev_cyc[2] - ev_cyc[1], 1);
    end
    chk("t3_rr_ptr", dut.ptr_q, 0);

    // 4: stalled consumer, repeated presses and overrun
    do_reset();
    ready = 1'b0;
    press(1, 8);
    chk("t4_valid", valid, 1);
    chk("t4_idx", idx, 1);
    press(1, 8);
    chk("t4_ovr_first", ovr[1], 0);
    press(1, 8);
    chk("t4_ovr_second", ovr[1], 1);
    chk("t4_idx_held", idx, 1);
    ovr_clr = 1'b1;
    cycle();
    ovr_clr = 1'b0;
    chk("t4_ovr_clr", ovr, 0);

    // 5: reset while an event is held
    chk("t5_pre_valid", valid, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_valid_async", valid, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    ready = 1'b1;
    clr_log();
    repeat (20) cycle();
    chk("t5_count", ev_idx.size(), 0);

`ifdef BTN_LONGPRESS_EN
    // 6: long hold gives one press and one long event
    do_reset();
    align();
    btn[3] = 1'b1;
    repeat (40) cycle();
    btn[3] = 1'b0;
    repeat (16) cycle();
    chk("t6_count", ev_idx.size(), 2);
    if (ev_idx.size() == 2) begin
      chk("t6_idx0", ev_idx[0], 3);
      chk("t6_long0", ev_long[0], 0);
      chk("t6_idx1", ev_idx[1], 3);
      chk("t6_long1", ev_long[1], 1);
    end
`endif

    // Random traffic against the model
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      ready   = ($urandom_range(0, 3) != 0);
      ovr_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
